// File: rtl/vga_timing_gen.sv
// Free-running raster timing generator (SVGA 800x600 @ 60 Hz by default).
// Every output is a register loaded from next-state counts, so each cycle presents one consistent tuple.
module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [10:0] hcount,
    output logic        hsync,
    output logic        hblnk,
    output logic [10:0] vcount,
    output logic        vsync,
    output logic        vblnk,
    output logic        frame_start,
    output logic        vblank_start
);

    localparam logic [10:0] H_LAST     = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] H_BLNK_BEG = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_LAST     = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] V_BLNK_BEG = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] h_q, h_d;
    logic [10:0] v_q, v_d;
    logic        hsync_q, hsync_d;
    logic        hblnk_q, hblnk_d;
    logic        vsync_q, vsync_d;
    logic        vblnk_q, vblnk_d;
    logic        fs_q, fs_d;
    logic        vbs_q, vbs_d;
    logic        h_wrap, v_wrap;

    always_comb begin
        // Disabled cycles hold every count and level; only the strobes drop.
        h_d     = h_q;
        v_d     = v_q;
        hsync_d = hsync_q;
        hblnk_d = hblnk_q;
        vsync_d = vsync_q;
        vblnk_d = vblnk_q;
        fs_d    = 1'b0;
        vbs_d   = 1'b0;
        h_wrap  = 1'b0;
        v_wrap  = 1'b0;
        if (en) begin
            // >= keeps the counters bounded even from an out-of-range state.
            h_wrap  = (h_q >= H_LAST);
            v_wrap  = (v_q >= V_LAST);
            h_d     = h_wrap ? 11'd0 : h_q + 11'd1;
            if (h_wrap) begin
                v_d = v_wrap ? 11'd0 : v_q + 11'd1;
            end
            hblnk_d = (h_d >= H_BLNK_BEG);
            hsync_d = (h_d >= H_SYNC_BEG) && (h_d < H_SYNC_END);
            vblnk_d = (v_d >= V_BLNK_BEG);
            vsync_d = (v_d >= V_SYNC_BEG) && (v_d < V_SYNC_END);
            fs_d    = h_wrap && v_wrap;
            vbs_d   = h_wrap && (v_d == V_BLNK_BEG);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q     <= 11'd0;
            v_q     <= 11'd0;
            hsync_q <= 1'b0;
            hblnk_q <= 1'b0;
            vsync_q <= 1'b0;
            vblnk_q <= 1'b0;
            fs_q    <= 1'b0;
            vbs_q   <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            hblnk_q <= hblnk_d;
            vsync_q <= vsync_d;
            vblnk_q <= vblnk_d;
            fs_q    <= fs_d;
            vbs_q   <= vbs_d;
        end
    end

    assign hcount       = h_q;
    assign vcount       = v_q;
    assign hsync        = hsync_q;
    assign hblnk        = hblnk_q;
    assign vsync        = vsync_q;
    assign vblnk        = vblnk_q;
    assign frame_start  = fs_q;
    assign vblank_start = vbs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken raster (15 x 10, 150-cycle frame).
// Horizontal: active 0..7, sync 10..12; vertical: active 0..5, sync 7..8.
module tb_vga_timing_gen;

    logic        clk;
    logic        rst;
    logic        en;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic        frame_start;
    logic        vblank_start;

    int n_checks = 0;
    int n_fail   = 0;
    int pos_n    = 0;   // enabled cycles since reset release
    int tcyc     = 0;   // all cycles since reset release
    int fs_cnt   = 0;
    int fs_t     = 0;
    int vbs_cnt  = 0;
    int hs_cnt   = 0;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .hcount(hcount), .hsync(hsync), .hblnk(hblnk),
        .vcount(vcount), .vsync(vsync), .vblnk(vblnk),
        .frame_start(frame_start), .vblank_start(vblank_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected levels come from the hand-written raster ranges above.
    task automatic chk_tuple(input string tag, input int eh, input int ev, input bit efs, input bit evbs);
        chk({tag, ".hcount"}, hcount, 11'(eh));
        chk({tag, ".vcount"}, vcount, 11'(ev));
        chk({tag, ".hblnk"}, {10'd0, hblnk}, {10'd0, (eh >= 8)});
        chk({tag, ".hsync"}, {10'd0, hsync}, {10'd0, (eh >= 10 && eh <= 12)});
        chk({tag, ".vblnk"}, {10'd0, vblnk}, {10'd0, (ev >= 6)});
        chk({tag, ".vsync"}, {10'd0, vsync}, {10'd0, (ev == 7 || ev == 8)});
        chk({tag, ".frame_start"}, {10'd0, frame_start}, {10'd0, efs});
        chk({tag, ".vblank_start"}, {10'd0, vblank_start}, {10'd0, evbs});
    endtask

    task automatic note_strobes();
        if (frame_start === 1'b1) begin
            fs_cnt++;
            fs_t = tcyc;
        end
        if (vblank_start === 1'b1) vbs_cnt++;
        if (hsync === 1'b1) hs_cnt++;
    endtask

    task automatic do_reset(input logic en_val);
        rst = 1'b1;
        en  = en_val;
        step();
        rst = 1'b0;
        pos_n = 0; tcyc = 0; fs_cnt = 0; fs_t = 0; vbs_cnt = 0; hs_cnt = 0;
        chk_tuple("reset", 0, 0, 1'b0, 1'b0);
    endtask

    task automatic advance(input string tag, input int cycles);
        en = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            step();
            pos_n++;
            tcyc++;
            note_strobes();
            chk_tuple(tag, pos_n % 15, (pos_n / 15) % 10,
                      (pos_n % 150 == 0), (pos_n % 150 == 90));
        end
    endtask

    task automatic hold(input string tag, input int cycles);
        en = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            step();
            tcyc++;
            note_strobes();
            chk_tuple(tag, pos_n % 15, (pos_n / 15) % 10, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        step();

        // Two full frames from reset.
        do_reset(1'b1);
        advance("run", 300);
        chk("fs_count", 11'(fs_cnt), 11'd2);
        chk("fs_last_time", 11'(fs_t), 11'd300);
        chk("vbs_count", 11'(vbs_cnt), 11'd2);
        chk("hsync_cycles", 11'(hs_cnt), 11'd60);

        // First frame_start time after reset, without disturbance.
        do_reset(1'b1);
        advance("first", 150);
        chk("fs_first_time", 11'(fs_t), 11'd150);

        // Enable dropped for 50 cycles at the last active pixel (7,1).
        do_reset(1'b1);
        advance("pre_hold", 22);
        hold("hold", 50);
        advance("resume", 1);
        chk("resume_hblnk", {10'd0, hblnk}, 11'd1);
        advance("post_hold", 127);
        chk("stretched_period", 11'(fs_t), 11'd200);
        chk("stretched_fs_count", 11'(fs_cnt), 11'd1);

        // Reset mid-frame at (5,3), with and without enable.
        do_reset(1'b1);
        advance("pre_rst", 50);
        do_reset(1'b1);
        advance("pre_rst_en0", 7);
        do_reset(1'b0);

        // Reset one cycle before vblank_start: the strobe is dropped.
        advance("pre_vbs", 89);
        do_reset(1'b1);
        advance("after_drop", 1);

        // Enable held low across the frame wrap at (14,9).
        do_reset(1'b1);
        advance("pre_wrap", 149);
        fs_cnt = 0;
        hold("wrap_hold", 10);
        chk("wrap_hold_fs", 11'(fs_cnt), 11'd0);
        advance("wrap", 1);
        advance("post_wrap", 5);
        chk("wrap_fs_count", 11'(fs_cnt), 11'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
